// File: rtl/bus_master_pkg.sv
// ============================================================================
// Module  : bus_master_pkg
// Purpose : Shared types for the command-driven bus master: FSM state
//           encoding and the default-width command record.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package bus_master_pkg;

  // Default command field widths (match the bus_master_seq defaults).
  localparam int CMD_ADDR_W = 16;
  localparam int CMD_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef struct packed {
    logic                  write;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
  } cmd_t;

endpackage

`default_nettype wire

// File: rtl/bus_master_seq_fifo.sv
// ============================================================================
// Module  : sync_fifo
// Purpose : Single-clock FIFO with occupancy count. Push to a full FIFO and
//           pop from an empty FIFO are ignored.
// Ports   : clk, reset (async, active-low)
//           push/wdata  - write side
//           pop/rdata   - read side; rdata shows the head entry
//           full, empty, count - occupancy
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/bus_master_seq.sv
// ============================================================================
// Module  : bus_master_seq
// Purpose : Command-driven bus master. Commands are queued in a FIFO and
//           issued one at a time with a valid/ready handshake; one response
//           (read data or timeout error) is returned per command, in order.
// Ports   : clk, reset (async, active-low)
//           cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata - command input
//           rsp_valid/rsp_rdata/rsp_err - one-cycle response pulse
//           busy - work queued or in progress
//           busa_valid/read/write/addr/write_data - bus request (registered)
//           busa_ready/busa_read_data - bus completion from the slave
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_master_seq
  import bus_master_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              busa_valid,
  output logic              busa_read,
  output logic              busa_write,
  output logic [ADDR_W-1:0] busa_addr,
  output logic [DATA_W-1:0] busa_write_data,
  input  logic              busa_ready,
  input  logic [DATA_W-1:0] busa_read_data
);
  localparam int CMD_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(CMD_DEPTH) + 1;
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TMR_W-1:0] TMR_SAT   = {TMR_W{1'b1}};
  localparam logic [CNT_W:0]   DEPTH_CNT = (CNT_W + 1)'(CMD_DEPTH);

  state_e             state, state_nxt;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [CMD_W-1:0]   fifo_head;
  logic [CNT_W:0]     count_nxt;
  logic               ready_nxt;

  logic               valid_nxt, read_nxt, write_nxt, clr_bus;
  logic [ADDR_W-1:0]  addr_nxt;
  logic [DATA_W-1:0]  wdata_nxt;
  logic [TMR_W-1:0]   timer, timer_nxt;
  logic               rsp_valid_nxt, rsp_err_nxt;
  logic [DATA_W-1:0]  rsp_rdata_nxt;

  logic               head_write;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_wdata;

  assign fifo_push  = cmd_valid && cmd_ready && !fifo_full;
  assign head_write = fifo_head[CMD_W-1];
  assign head_addr  = fifo_head[DATA_W +: ADDR_W];
  assign head_wdata = fifo_head[DATA_W-1:0];
  assign busy       = !fifo_empty || (state != ST_IDLE);

  sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata ({cmd_write, cmd_addr, cmd_wdata}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // cmd_ready is registered so it reads 0 throughout reset; it tracks the
  // occupancy the FIFO will have after this edge (no same-cycle bypass).
  assign count_nxt = {1'b0, fifo_count} + (CNT_W + 1)'(fifo_push)
                     - (CNT_W + 1)'(fifo_pop);
  assign ready_nxt = (count_nxt < DEPTH_CNT);

  always_comb begin
    state_nxt     = state;
    fifo_pop      = 1'b0;
    clr_bus       = 1'b0;
    valid_nxt     = busa_valid;
    read_nxt      = busa_read;
    write_nxt     = busa_write;
    addr_nxt      = busa_addr;
    wdata_nxt     = busa_write_data;
    timer_nxt     = timer;
    rsp_valid_nxt = 1'b0;
    rsp_rdata_nxt = rsp_rdata;
    rsp_err_nxt   = rsp_err;

    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          valid_nxt = 1'b1;
          read_nxt  = !head_write;
          write_nxt = head_write;
          addr_nxt  = head_addr;
          wdata_nxt = head_write ? head_wdata : '0;
          timer_nxt = '0;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // ready on the last permitted cycle completes normally.
        if (busa_ready) begin
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = busa_read ? busa_read_data : '0;
          rsp_err_nxt   = 1'b0;
          clr_bus       = 1'b1;
          state_nxt     = ST_RESP;
        end else if ((TIMEOUT != 0) && (timer == TMR_LAST)) begin
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = '0;
          rsp_err_nxt   = 1'b1;
          clr_bus       = 1'b1;
          state_nxt     = ST_RESP;
        end else if (timer != TMR_SAT) begin
          timer_nxt = timer + 1'b1;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: begin
        clr_bus   = 1'b1;
        state_nxt = ST_IDLE;
      end
    endcase

    if (clr_bus) begin
      valid_nxt = 1'b0;
      read_nxt  = 1'b0;
      write_nxt = 1'b0;
      addr_nxt  = '0;
      wdata_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= ST_IDLE;
      cmd_ready       <= 1'b0;
      busa_valid      <= 1'b0;
      busa_read       <= 1'b0;
      busa_write      <= 1'b0;
      busa_addr       <= '0;
      busa_write_data <= '0;
      timer           <= '0;
      rsp_valid       <= 1'b0;
      rsp_rdata       <= '0;
      rsp_err         <= 1'b0;
    end else begin
      state           <= state_nxt;
      cmd_ready       <= ready_nxt;
      busa_valid      <= valid_nxt;
      busa_read       <= read_nxt;
      busa_write      <= write_nxt;
      busa_addr       <= addr_nxt;
      busa_write_data <= wdata_nxt;
      timer           <= timer_nxt;
      rsp_valid       <= rsp_valid_nxt;
      rsp_rdata       <= rsp_rdata_nxt;
      rsp_err         <= rsp_err_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_master_seq.sv
// ============================================================================
// Module  : tb_bus_master_seq
// Purpose : Self-checking bench for bus_master_seq (TIMEOUT = 8).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bus_master_seq;
  import bus_master_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_err, busy;
  logic [DW-1:0] rsp_rdata;
  logic          busa_valid, busa_read, busa_write, busa_ready;
  logic [AW-1:0] busa_addr;
  logic [DW-1:0] busa_write_data, busa_read_data;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bus_master_seq #(.ADDR_W(AW), .DATA_W(DW), .CMD_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .busa_valid(busa_valid), .busa_read(busa_read), .busa_write(busa_write),
    .busa_addr(busa_addr), .busa_write_data(busa_write_data),
    .busa_ready(busa_ready), .busa_read_data(busa_read_data)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- slave model ----------------
  logic          rd_ovr_en;
  logic [DW-1:0] rd_ovr;
  logic          slave_rand;
  int            rdy_pct;

  // Random-mode slave behaves like a memory whose contents derive from the address.
  always_comb busa_read_data = rd_ovr_en ? rd_ovr : {~busa_addr, busa_addr};

  always @(posedge clk) begin
    if (slave_rand) begin
      #1;
      busa_ready = ($urandom_range(0, 99) < rdy_pct);
    end
  end

  // ---------------- transaction-level reference model ----------------
  cmd_t          pend[$];
  cmd_t          cur;
  bit            in_txn, rsp_due;
  logic [DW-1:0] exp_rd;
  logic          exp_err;
  int            mon_hold, gap;

  always @(negedge clk) begin
    if (!reset) begin
      pend.delete();
      in_txn  = 0;
      rsp_due = 0;
      gap     = 99;
      mon_hold = 0;
    end else begin
      // A response is owed exactly one cycle after completion or timeout.
      if (rsp_due) begin
        chk("mon_rsp_valid", rsp_valid, 1);
        chk("mon_rsp_rdata", rsp_rdata, exp_rd);
        chk("mon_rsp_err", rsp_err, exp_err);
        chk("mon_valid_low_in_rsp", busa_valid, 0);
        rsp_due = 0;
      end else begin
        chk("mon_no_spurious_rsp", rsp_valid, 0);
      end

      if (busa_valid) begin
        if (!in_txn) begin
          chk("mon_idle_gap", gap >= 2, 1);
          chk("mon_issue_has_cmd", pend.size() > 0, 1);
          if (pend.size() > 0) cur = pend.pop_front();
          in_txn   = 1;
          mon_hold = 0;
        end
        chk("mon_write", busa_write, cur.write);
        chk("mon_read", busa_read, !cur.write);
        chk("mon_addr", busa_addr, cur.addr);
        chk("mon_wdata", busa_write_data, cur.write ? cur.wdata : '0);
        mon_hold++;
        if (busa_ready) begin
          exp_rd  = cur.write ? '0 : busa_read_data;
          exp_err = 1'b0;
          rsp_due = 1;
          in_txn  = 0;
        end else if (mon_hold == TMO) begin
          exp_rd  = '0;
          exp_err = 1'b1;
          rsp_due = 1;
          in_txn  = 0;
        end
        gap = 0;
      end else begin
        if (in_txn) begin
          chk("mon_valid_held", busa_valid, 1);
          in_txn = 0;
        end
        gap++;
      end

      if (cmd_valid && cmd_ready) begin
        cmd_t c;
        c.write = cmd_write;
        c.addr  = cmd_addr;
        c.wdata = cmd_wdata;
        pend.push_back(c);
      end
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] slv_rdata;
    int            delay;      // ISSUE cycle index at which ready rises
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int            exp_hold;   // cycles valid stays high
  } vec_t;

  vec_t vecs[7];

  task automatic wait_idle(input string name);
    int t = 0;
    @(negedge clk);
    while ((busy || rsp_due) && t < 600) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_drain_bound"}, t < 600, 1);
    chk({name, "_model_empty"}, pend.size(), 0);
  endtask

  task automatic offer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input string name);
    int t = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    @(negedge clk);
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_accept_bound"}, t < 200, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold, refused, t;

    vecs[0] = '{1'b1, 16'h0010, 32'hDEADBEEF, 32'h0,        0,  32'h0,        1'b0, 1};
    vecs[1] = '{1'b0, 16'h0010, 32'h11111111, 32'hDEADBEEF, 5,  32'hDEADBEEF, 1'b0, 6};
    vecs[2] = '{1'b1, 16'h1234, 32'hCAFEF00D, 32'h5A5A5A5A, 3,  32'h0,        1'b0, 4};
    vecs[3] = '{1'b0, 16'hFFFF, 32'h0,        32'h12345678, 7,  32'h12345678, 1'b0, 8};
    vecs[4] = '{1'b0, 16'h0001, 32'h0,        32'hA5A5A5A5, 8,  32'h0,        1'b1, 8};
    vecs[5] = '{1'b1, 16'h8000, 32'h00000001, 32'h77777777, 20, 32'h0,        1'b1, 8};
    vecs[6] = '{1'b0, 16'h0000, 32'h0,        32'hFFFFFFFF, 0,  32'hFFFFFFFF, 1'b0, 1};

    // ---- reset behaviour ----
    reset = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0055;
    cmd_wdata = 32'h12345678; busa_ready = 1'b0; rd_ovr_en = 1'b0; rd_ovr = '0;
    slave_rand = 1'b0; rdy_pct = 50;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_busa_valid", busa_valid, 0);
    chk("rst_busa_read", busa_read, 0);
    chk("rst_busa_write", busa_write, 0);
    chk("rst_busa_addr", busa_addr, 0);
    chk("rst_busa_wdata", busa_write_data, 0);
    @(posedge clk); #1;
    reset = 1'b1; cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst_release_ready_same_cycle", cmd_ready, 0);
    @(negedge clk);
    chk("rst_release_ready_next_cycle", cmd_ready, 1);

    // ---- table-driven single transactions ----
    for (int i = 0; i < 7; i++) begin
      rd_ovr_en = 1'b1; rd_ovr = vecs[i].slv_rdata; busa_ready = 1'b0;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_write = vecs[i].write;
      cmd_addr = vecs[i].addr; cmd_wdata = vecs[i].wdata;
      @(negedge clk);                                   // cycle N (accept)
      chk($sformatf("v%0d_cmd_ready", i), cmd_ready, 1);
      @(posedge clk); #1; cmd_valid = 1'b0;
      @(negedge clk);                                   // cycle N+1
      chk($sformatf("v%0d_valid_n1", i), busa_valid, 0);
      @(posedge clk); #1; busa_ready = (vecs[i].delay == 0);
      @(negedge clk);                                   // cycle N+2
      chk($sformatf("v%0d_valid_n2", i), busa_valid, 1);
      chk($sformatf("v%0d_write", i), busa_write, vecs[i].write);
      chk($sformatf("v%0d_read", i), busa_read, !vecs[i].write);
      chk($sformatf("v%0d_addr", i), busa_addr, vecs[i].addr);
      chk($sformatf("v%0d_wdata", i), busa_write_data,
          vecs[i].write ? vecs[i].wdata : 32'h0);
      hold = 0;
      while (busa_valid && hold < 30) begin
        hold++;
        @(posedge clk); #1; busa_ready = (hold == vecs[i].delay);
        @(negedge clk);
      end
      chk($sformatf("v%0d_hold", i), hold, vecs[i].exp_hold);
      chk($sformatf("v%0d_rsp_valid", i), rsp_valid, 1);
      chk($sformatf("v%0d_rsp_rdata", i), rsp_rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d_rsp_err", i), rsp_err, vecs[i].exp_err);
      @(posedge clk); #1; busa_ready = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_rsp_pulse_end", i), rsp_valid, 0);
    end
    rd_ovr_en = 1'b0;

    // ---- back-pressure: 5 back-to-back with ready held low ----
    busa_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_write = k[0]; cmd_addr = AW'(16'h0100 + k);
      cmd_wdata = DW'(32'hB0000000 + k);
      @(negedge clk);
      chk($sformatf("bp_accept_%0d", k), cmd_ready, 1);
    end
    @(posedge clk); #1;
    cmd_write = 1'b1; cmd_addr = 16'h0200; cmd_wdata = 32'hB6B6B6B6;
    refused = 0;
    @(negedge clk);
    while (!cmd_ready && refused < 40) begin
      chk("bp_busy", busy, 1);
      refused++;
      @(negedge clk);
    end
    // First command times out (TMO cycles), then RESP and IDLE pop free a slot.
    chk("bp_refused_cycles", refused, 7);
    @(posedge clk); #1; cmd_valid = 1'b0;
    slave_rand = 1'b1; rdy_pct = 50;
    wait_idle("bp");

    // ---- randomized traffic ----
    rdy_pct = 70;
    for (int i = 0; i < 70; i++) begin
      if (i == 40) rdy_pct = 15;
      offer(1'($urandom), AW'($urandom), DW'($urandom), "rand");
      @(posedge clk); #1; cmd_valid = 1'b0;
      t = $urandom_range(0, 2);
      repeat (t) @(posedge clk);
    end
    wait_idle("rand");

    // ---- reset during ISSUE with two commands queued ----
    slave_rand = 1'b0;
    @(posedge clk); #1; busa_ready = 1'b0;
    for (int k = 0; k < 3; k++)
      offer(1'b1, AW'(16'h0300 + k), DW'(32'hC0000000 + k), "rmid");
    @(posedge clk); #1; cmd_valid = 1'b0;
    @(negedge clk);
    chk("rmid_valid_before", busa_valid, 1);
    @(posedge clk); #1; reset = 1'b0;
    #1;
    chk("rmid_valid_dropped", busa_valid, 0);
    chk("rmid_busy_dropped", busy, 0);
    chk("rmid_cmd_ready", cmd_ready, 0);
    @(posedge clk); #1; reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("rmid_no_rsp", rsp_valid, 0);
      chk("rmid_no_valid", busa_valid, 0);
      chk("rmid_not_busy", busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
